// File: rtl/nanci_row_drain.sv
// nanci_row_drain: captures all N PE words of i_row on i_start (in IDLE) and streams them PE 0 first over o_valid/i_ready, flagging PE N-1 with o_last, o_busy outside IDLE, o_done one cycle after the last transfer; rst is synchronous active-low; defining NANCI_ORDER_CHECK_EN adds the sticky o_order_err flag for a data field smaller than the previous one
module nanci_row_drain #(
  parameter int N = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic [N*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_row,
  input  logic i_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_word,
  output logic o_valid,
  output logic o_last,
  output logic o_busy,
  output logic o_done
`ifdef NANCI_ORDER_CHECK_EN
  ,
  output logic o_order_err
`endif
);
  localparam int W = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] buf_q [N];
  logic [W-1:0] buf_d [N];
  logic cap, last, xfer;
`ifdef NANCI_ORDER_CHECK_EN
  logic err_q, err_d;
`endif
  always_comb begin
    cap = state_q == IDLE && i_start;
    last = state_q == DRAIN && idx_q == LAST_IDX;
    xfer = state_q == DRAIN && i_ready;
    state_d = cap ? DRAIN : (xfer && last) ? DONE : state_q == DONE ? IDLE : state_q;
    idx_d = cap ? '0 : (xfer && !last) ? idx_q + 1'b1 : idx_q;
    buf_d = buf_q;
    if (cap)
      for (int k = 0; k < N; k++) buf_d[k] = i_row[k*W +: W];
`ifdef NANCI_ORDER_CHECK_EN
    err_d = cap ? 1'b0 : err_q | (xfer && idx_q != '0 &&
            buf_q[idx_q][DATA_WIDTH-1:0] < buf_q[idx_q - 1'b1][DATA_WIDTH-1:0]);
    o_order_err = err_q;
`endif
    o_valid = state_q == DRAIN;
    o_word = o_valid ? buf_q[idx_q] : '0;
    o_last = last;
    o_busy = state_q != IDLE;
    o_done = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      for (int k = 0; k < N; k++) buf_q[k] <= '0;
`ifdef NANCI_ORDER_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
`ifdef NANCI_ORDER_CHECK_EN
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: doc/nanci_row_drain.md
# nanci_row_drain

Result-drain stage that sits directly downstream of a row of Nanci mesh PEs. When sorting finishes, it snapshots the `o_PE` words of all N PEs in the row in a single cycle. It then streams them out one per transfer, PE 0 first, over a valid/ready handshake to the host-side collector. An optional checker flags any out-of-order data field in the streamed row.

## Interface
- `N`, 4: number of PEs in the row (≥1).
- `ADDR_WIDTH`, 3: address field width of a PE word.
- `DATA_WIDTH`, 3: data field width of a PE word; word width W = ADDR_WIDTH+DATA_WIDTH (6 by default, matching `o_PE`).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse: the row's `o_PE` outputs are final; capture now.
- `i_row`  in  N*W  concatenated PE outputs; PE k occupies bits [k*W+W-1 : k*W].
- `i_ready`  in  1  downstream accepts `o_word` this cycle.
- `o_word`  out  W  current word; bits [W-1:DATA_WIDTH] = addr, [DATA_WIDTH-1:0] = data.
- `o_valid`  out  1  `o_word` is valid.
- `o_last`  out  1  the word on `o_word` is PE N-1's (qualified by `o_valid`).
- `o_busy`  out  1  high whenever the FSM is not in IDLE.
- `o_done`  out  1  one-cycle pulse after the last word is accepted.
- `o_order_err`  out  1  sticky order-violation flag; present only with `NANCI_ORDER_CHECK_EN`.

## Operation
- FSM states:
  - IDLE: `i_start`=1 → latch all N words of `i_row` into the capture buffer, set idx=0, go to DRAIN.
  - DRAIN: `o_valid`=1 and `o_word`=buf[idx]. A transfer occurs when `o_valid`&&`i_ready`. On a transfer with idx==N-1 → go to DONE; on any other transfer → idx+1.
  - DONE: `o_done`=1 for exactly one cycle, then → IDLE.
- `i_start` is ignored outside IDLE. The buffer is not re-latched, and no error is raised.
- idx is $clog2(N) bits wide (minimum 1). It never wraps past N-1.
- Once latched, the buffer is stable; changes on `i_row` after capture have no effect.
- `o_last` = (idx==N-1) && state==DRAIN.
- With N=1: IDLE → DRAIN for one word (`o_last`=1) → DONE.
- Holding `i_ready` low stalls indefinitely. `o_word` must stay stable while `o_valid`=1 and no transfer occurs.
- Reset (`rst`=0 at a posedge), including mid-DRAIN:
  - state=IDLE, idx=0, buffer cleared to 0;
  - `o_valid`=0, `o_last`=0, `o_busy`=0, `o_done`=0, `o_order_err`=0, `o_word`=0;
  - any partially drained row is discarded.

## Timing
- Capture: `i_start` sampled high at posedge k → `o_valid`=1 with `o_word`=PE 0 word from posedge k (the cycle after the pulse).
- Throughput: one word per cycle when `i_ready` is held high. A full row takes N cycles in DRAIN, plus 1 cycle DONE.
- Last transfer at posedge m → `o_done`=1 during cycle m..m+1 and `o_busy` still 1. IDLE from posedge m+1.
- Earliest re-capture: `i_start` sampled at posedge m+1 is honoured (it is sampled in IDLE).
- All outputs are decoded from registered state, buffer and idx only. There are no combinational paths from `i_ready` or `i_start`.

## Configuration
- Macro `NANCI_ORDER_CHECK_EN`.
- Defined:
  - On each transfer after the first of a row, compare the transferred data field with the data field of the previous transfer (unsigned).
  - If current < previous, set `o_order_err`=1 the next cycle.
  - The flag is sticky until reset or the next accepted `i_start`, which clears it.
  - Addr fields are not checked.
- Undefined: the `o_order_err` port and the comparison logic are absent. Everything else is unchanged.

## Test plan
- Reset + basic drain (N=4, `i_ready`=1): `i_row`={PE3=6'b011111, PE2=6'b010101, PE1=6'b001011, PE0=6'b000001}, `i_start` pulse → `o_word` 000001, 001011, 010101, 011111 on 4 consecutive cycles; `o_last` only on 011111; `o_done` pulse the next cycle.
- Backpressure: same row, `i_ready` low for 3 cycles after the first word → `o_word` holds 001011 with `o_valid`=1 throughout, and no word is lost or duplicated.
- Ignored start: pulse `i_start` with a different `i_row` while in DRAIN → the remaining words still come from the original capture, and `o_busy` stays 1.
- Reset mid-drain: assert `rst`=0 after the second transfer → next cycle `o_valid`=0, `o_busy`=0, `o_word`=0; a new `i_start` restarts from PE 0.
- N=1: `i_row`=6'b100000 → one word 100000 with `o_last`=1, then `o_done`.
- With `NANCI_ORDER_CHECK_EN`:
  - data sequence 1,3,2,5 → `o_order_err` rises the cycle after the third transfer and stays set;
  - a subsequent `i_start` clears it;
  - an ascending row keeps it 0.
